pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC from sequential, branch, jump,
// register-jump and return paths, backed by a circular return-address stack.
module pc_sequencer #(
  parameter int XLEN = 32,
  parameter int RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic                             Less,
  input  logic                             Zero,
  input  logic [2:0]                       Condition,
  input  logic [XLEN-3:0]                  Ex_offset,
  input  logic [25:0]                      IR,
  input  logic [XLEN-1:0]                  jr_target,
  input  logic [1:0]                       Jump_mode,
  input  logic                             link,
  output logic [XLEN-1:0]                  Pc,
  output logic [XLEN-1:0]                  next_pc,
  output logic                             redirect,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {
    MODE_SEQ = 2'b00,
    MODE_ABS = 2'b01,
    MODE_REG = 2'b10,
    MODE_RET = 2'b11
  } jump_mode_t;

  jump_mode_t      mode;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] reg_target;
  logic [XLEN-1:0] ras_top;
  logic            taken;
  logic            ras_empty;
  logic            do_push;
  logic            do_pop;
  logic            ret_on_empty;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   wr_ptr_inc;
  logic [PW-1:0]   wr_ptr_dec;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic            unused_jr_bits;

  assign mode           = jump_mode_t'(Jump_mode);
  assign pc4            = Pc + XLEN'(4);
  assign branch_target  = pc4 + {Ex_offset, 2'b00};
  assign jump_target    = {pc4[XLEN-1:28], IR, 2'b00};
  assign reg_target     = {jr_target[XLEN-1:2], 2'b00};
  assign unused_jr_bits = ^jr_target[1:0];

  // wr_ptr names the next free slot, so the top of stack sits one behind it
  assign wr_ptr_inc = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign wr_ptr_dec = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - PW'(1);
  assign ras_top    = ras_mem[wr_ptr_dec];

  assign ras_empty    = (ras_count == '0);
  assign do_push      = link && (mode != MODE_SEQ);
  assign do_pop       = (mode == MODE_RET) && !ras_empty;
  assign ret_on_empty = (mode == MODE_RET) && ras_empty;

  always_comb begin
    taken = 1'b0;
    case (Condition)
      3'd0: taken = 1'b0;
      3'd1: taken = Zero;
      3'd2: taken = ~Zero;
      3'd3: taken = ~Less;
      3'd4: taken = ~(Less | Zero);
      3'd5: taken = Less | Zero;
      3'd6: taken = Less;
      3'd7: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc4;
    case (mode)
      MODE_SEQ: next_pc = taken ? branch_target : pc4;
      MODE_ABS: next_pc = jump_target;
      MODE_REG: next_pc = reg_target;
      MODE_RET: next_pc = ras_empty ? reg_target : ras_top;
      default:  next_pc = pc4;
    endcase
  end

  assign redirect = (next_pc != pc4);

  // A call that is also a return swaps the top in place, so neither pointer nor count moves
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Pc            <= RESET_PC;
      wr_ptr        <= '0;
      ras_count     <= '0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      Pc            <= next_pc;
      ras_underflow <= ret_on_empty;
      if (do_push && !do_pop) begin
        wr_ptr <= wr_ptr_inc;
        if (ras_count != CW'(RAS_DEPTH)) begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (do_pop && !do_push) begin
        wr_ptr    <= wr_ptr_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !stall && do_push) begin
      if (do_pop) begin
        ras_mem[wr_ptr_dec] <= pc4;
      end else begin
        ras_mem[wr_ptr] <= pc4;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int XLEN = 32;
  localparam int RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        Less;
  logic        Zero;
  logic [2:0]  Condition;
  logic [29:0] Ex_offset;
  logic [25:0] IR;
  logic [31:0] jr_target;
  logic [1:0]  Jump_mode;
  logic        link;
  logic [31:0] Pc;
  logic [31:0] next_pc;
  logic        redirect;
  logic [2:0]  ras_count;
  logic        ras_underflow;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  bit          m_under;

  pc_sequencer #(
    .XLEN(XLEN),
    .RAS_DEPTH(RAS_DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .Less(Less),
    .Zero(Zero),
    .Condition(Condition),
    .Ex_offset(Ex_offset),
    .IR(IR),
    .jr_target(jr_target),
    .Jump_mode(Jump_mode),
    .link(link),
    .Pc(Pc),
    .next_pc(next_pc),
    .redirect(redirect),
    .ras_count(ras_count),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [2:0] cond, input logic lss,
                               input logic zr, input logic [29:0] off, input logic [25:0] ir_v,
                               input logic [31:0] jr, input logic lnk, input logic stl);
    Jump_mode = mode;
    Condition = cond;
    Less      = lss;
    Zero      = zr;
    Ex_offset = off;
    IR        = ir_v;
    jr_target = jr;
    link      = lnk;
    stall     = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic bit model_taken();
    case (Condition)
      3'd0: return 1'b0;
      3'd1: return Zero;
      3'd2: return !Zero;
      3'd3: return !Less;
      3'd4: return !Less && !Zero;
      3'd5: return Less || Zero;
      3'd6: return Less;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_next();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    case (Jump_mode)
      2'd0: return model_taken() ? seq + 32'(int'($signed(Ex_offset)) * 4) : seq;
      2'd1: return (seq & 32'hF000_0000) | (32'(IR) << 2);
      2'd2: return jr_target & ~32'h3;
      default: return (m_stack.size() > 0) ? m_stack[$] : (jr_target & ~32'h3);
    endcase
  endfunction

  // Reference model advances on the same edge the DUT does, from the same inputs
  always @(posedge clk) begin : model_update
    logic [31:0] nxt;
    logic [31:0] seq;
    if (!rst_n) begin
      m_pc    = RESET_PC;
      m_stack.delete();
      m_under = 1'b0;
    end else if (!stall) begin
      nxt     = model_next();
      seq     = m_pc + 32'd4;
      m_under = (Jump_mode == 2'd3) && (m_stack.size() == 0);
      if ((Jump_mode == 2'd3) && (m_stack.size() > 0)) void'(m_stack.pop_back());
      if (link && (Jump_mode != 2'd0)) begin
        m_stack.push_back(seq);
        if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
      end
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("Pc", Pc, m_pc);
      checkOutput("ras_count", ras_count, 64'(m_stack.size()));
      checkOutput("ras_underflow", ras_underflow, m_under);
      checkOutput("next_pc", next_pc, model_next());
      checkOutput("redirect", redirect, model_next() != (m_pc + 32'd4));
    end
  end

  initial begin
    logic [31:0] call_tgt [5];
    logic [31:0] ret_exp [4];
    call_tgt = '{32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000};
    ret_exp  = '{32'h5004, 32'h4004, 32'h3004, 32'h2004};

    rst_n = 1'b0;
    applyStimulus(2'd0, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check_en = 1'b1;
    rst_n = 1'b1;

    settle();
    checkOutput("reset_pc", Pc, 32'h0);
    checkOutput("reset_count", ras_count, 3'd0);
    checkOutput("idle_redirect", redirect, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      settle();
      checkOutput("idle_pc", Pc, 32'(i * 4));
      checkOutput("idle_redirect", redirect, 1'b0);
    end

    // branch on Zero with a negative offset, held by stall so both flag values show
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h100, 1'b0, 1'b0);
    tick();
    applyStimulus(2'd0, 3'd1, 1'b0, 1'b1, 30'h3FFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b1);
    settle();
    checkOutput("br_pc", Pc, 32'h100);
    checkOutput("br_taken_target", next_pc, 32'h0FC);
    checkOutput("br_taken_redirect", redirect, 1'b1);
    tick();
    applyStimulus(2'd0, 3'd1, 1'b0, 1'b0, 30'h3FFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b1);
    settle();
    checkOutput("br_stall_pc", Pc, 32'h100);
    checkOutput("br_not_taken", next_pc, 32'h104);
    checkOutput("br_not_taken_redirect", redirect, 1'b0);
    tick();

    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h1000_0040, 1'b0, 1'b0);
    tick();
    applyStimulus(2'd1, 3'd5, 1'b1, 1'b1, 30'd0, 26'h10, 32'd0, 1'b1, 1'b0);
    settle();
    checkOutput("abs_next", next_pc, 32'h1000_0040);
    tick();
    applyStimulus(2'd3, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    settle();
    checkOutput("call_pc", Pc, 32'h1000_0040);
    checkOutput("call_count", ras_count, 3'd1);
    checkOutput("ret_next", next_pc, 32'h1000_0044);
    tick();
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, call_tgt[0], 1'b1, 1'b0);
    settle();
    checkOutput("ret_pc", Pc, 32'h1000_0044);
    checkOutput("ret_count", ras_count, 3'd0);
    checkOutput("ret_underflow", ras_underflow, 1'b0);

    // five nested calls into a four-deep stack: the oldest return is lost
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, call_tgt[i+1], 1'b1, 1'b0);
      else       applyStimulus(2'd3, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h7000, 1'b0, 1'b0);
    end
    settle();
    checkOutput("deep_count", ras_count, 3'd4);
    checkOutput("deep_pc", Pc, 32'h6000);
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      checkOutput("deep_ret_pc", Pc, ret_exp[i]);
      checkOutput("deep_ret_count", ras_count, 3'(3 - i));
    end
    checkOutput("fallback_next", next_pc, 32'h7000);
    tick();
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h8000, 1'b1, 1'b0);
    settle();
    checkOutput("fallback_pc", Pc, 32'h7000);
    checkOutput("underflow_pulse", ras_underflow, 1'b1);
    tick();
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h9000, 1'b1, 1'b0);
    settle();
    checkOutput("underflow_clear", ras_underflow, 1'b0);
    checkOutput("stall_setup_count", ras_count, 3'd1);
    tick();

    // stalled return with two entries: hold, then exactly one pop on release
    applyStimulus(2'd3, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h5_5550, 1'b0, 1'b1);
    settle();
    checkOutput("stall_pc", Pc, 32'h9000);
    checkOutput("stall_count", ras_count, 3'd2);
    checkOutput("stall_next", next_pc, 32'h8004);
    tick();
    settle();
    checkOutput("stall_hold_pc", Pc, 32'h9000);
    checkOutput("stall_hold_count", ras_count, 3'd2);
    tick();
    applyStimulus(2'd3, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h5_5550, 1'b0, 1'b0);
    settle();
    checkOutput("stall_hold2_pc", Pc, 32'h9000);
    tick();
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'hA000, 1'b1, 1'b0);
    settle();
    checkOutput("release_pc", Pc, 32'h8004);
    checkOutput("release_count", ras_count, 3'd1);
    tick();
    applyStimulus(2'd2, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'hB000, 1'b1, 1'b0);
    tick();

    // reset beats stall and a pending push/pop
    applyStimulus(2'd3, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'h0, 1'b1, 1'b1);
    rst_n = 1'b0;
    settle();
    checkOutput("prereset_count", ras_count, 3'd3);
    checkOutput("prereset_pc", Pc, 32'hB000);
    tick();
    rst_n = 1'b1;
    applyStimulus(2'd0, 3'd0, 1'b0, 1'b0, 30'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    settle();
    checkOutput("midreset_pc", Pc, RESET_PC);
    checkOutput("midreset_count", ras_count, 3'd0);
    checkOutput("midreset_underflow", ras_underflow, 1'b0);

    for (int n = 0; n < 600; n++) begin
      tick();
      rst_n = ($urandom_range(0, 99) >= 2);
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), 1'($urandom),
                    30'($urandom), 26'($urandom), $urandom,
                    ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15));
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
